// File: rtl/branch_predictor.sv
// Fetch-stage direction/target predictor with D-stage training, mispredict
// redirect (delay-slot aware) and resolved-branch statistics.
module branch_predictor #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned TAGW    = 30 - $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] f_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [3:0]  upd_branchop,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  input  logic        stall,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_cnt,
  output logic [31:0] miss_cnt
);
  localparam int unsigned IDX = $clog2(ENTRIES);

  logic            valid_q [ENTRIES];
  logic [TAGW-1:0] tag_q   [ENTRIES];
  logic [31:0]     tgt_q   [ENTRIES];
  logic [1:0]      ctr_q   [ENTRIES];
  logic [31:0]     br_cnt_q, br_cnt_d;
  logic [31:0]     miss_cnt_q, miss_cnt_d;

  logic [IDX-1:0]  f_idx, u_idx;
  logic [TAGW-1:0] f_tag, u_tag;
  logic            f_hit, u_hit, res, tbl_we;
  logic [1:0]      ctr_d;
  logic [31:0]     tgt_d;
  logic            unused_pc_bits;

  assign f_idx = f_pc[IDX+1:2];
  assign f_tag = f_pc[31:IDX+2];
  assign u_idx = upd_pc[IDX+1:2];
  assign u_tag = upd_pc[31:IDX+2];
  assign unused_pc_bits = ^{f_pc[1:0], upd_pc[1:0]};

  assign f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign pred_taken  = f_hit & ctr_q[f_idx][1];
  assign pred_target = pred_taken ? tgt_q[f_idx] : f_pc + 32'd4;

  // rst_n gates resolution so nothing is flagged or counted while in reset
  assign res = rst_n & upd_valid & (upd_branchop <= 4'd5) & ~stall;
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  assign mispredict  = res & ((upd_taken != upd_pred_taken) |
                              (upd_taken & (upd_pred_target != upd_target)));
  assign redirect_pc = upd_taken ? upd_target : upd_pc + 32'd8;

  assign br_cnt_d   = br_cnt_q + {31'd0, res};
  assign miss_cnt_d = miss_cnt_q + {31'd0, mispredict};
  assign br_cnt     = br_cnt_q;
  assign miss_cnt   = miss_cnt_q;

  always_comb begin
    tbl_we = 1'b0;
    ctr_d  = ctr_q[u_idx];
    tgt_d  = tgt_q[u_idx];
    if (res) begin
      if (u_hit) begin
        tbl_we = 1'b1;
        if (upd_taken) begin
          tgt_d = upd_target;
          if (ctr_q[u_idx] != 2'b11) ctr_d = ctr_q[u_idx] + 2'd1;
        end else if (ctr_q[u_idx] != 2'b00) begin
          ctr_d = ctr_q[u_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        tbl_we = 1'b1;
        ctr_d  = 2'b10;
        tgt_d  = upd_target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= 2'b01;
      end
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (tbl_we) begin
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
        tgt_q[u_idx]   <= tgt_d;
        ctr_q[u_idx]   <= ctr_d;
      end
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor: lookup, training,
// saturation, stall/non-branch qualification, aliasing, wrap and async reset.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] f_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [3:0]  upd_branchop;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        stall;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] br_cnt;
  logic [31:0] miss_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] exp_br = 0;
  logic [31:0] exp_miss = 0;

  branch_predictor #(.ENTRIES(16)) dut (
    .clk(clk), .rst_n(rst_n), .f_pc(f_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_branchop(upd_branchop),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .stall(stall), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .br_cnt(br_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic drive(input logic [31:0] pc, input logic [3:0] op, input logic tk,
                       input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = pc; upd_branchop = op; upd_taken = tk;
    upd_target = tgt; upd_pred_taken = ptk; upd_pred_target = ptgt;
    #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    upd_valid = 1'b0; stall = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; f_pc = 32'h0000_3000;
    upd_valid = 1'b1; upd_pc = 32'h0000_3000; upd_branchop = 4'd0; upd_taken = 1'b1;
    upd_target = 32'h0000_3100; upd_pred_taken = 1'b0; upd_pred_target = 32'h0000_3004;
    #1;
    total_cnt++; if (pred_taken !== 1'b0) $display("FAIL reset_pt got=%h exp=0", pred_taken); else pass_cnt++;
    total_cnt++; if (pred_target !== 32'h0000_3004) $display("FAIL reset_ptgt got=%h exp=00003004", pred_target); else pass_cnt++;
    total_cnt++; if (mispredict !== 1'b0) $display("FAIL reset_mp got=%h exp=0", mispredict); else pass_cnt++;
    total_cnt++; if (br_cnt !== 32'd0 || miss_cnt !== 32'd0) $display("FAIL reset_cnt got=%h/%h exp=0/0", br_cnt, miss_cnt); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1; upd_valid = 1'b0;
    tick();
    total_cnt++; if (br_cnt !== 32'd0) $display("FAIL idle_br got=%h exp=0", br_cnt); else pass_cnt++;
  endtask

  task automatic test_alloc();
    f_pc = 32'h0000_3010;
    drive(32'h0000_3010, 4'd0, 1'b1, 32'h0000_3040, 1'b0, 32'h0000_3014);
    total_cnt++; if (mispredict !== 1'b1) $display("FAIL alloc_mp got=%h exp=1", mispredict); else pass_cnt++;
    total_cnt++; if (redirect_pc !== 32'h0000_3040) $display("FAIL alloc_redir got=%h exp=00003040", redirect_pc); else pass_cnt++;
    total_cnt++; if (pred_taken !== 1'b0) $display("FAIL no_bypass got=%h exp=0", pred_taken); else pass_cnt++;
    tick(); exp_br = 1; exp_miss = 1;
    total_cnt++; if (br_cnt !== exp_br || miss_cnt !== exp_miss) $display("FAIL alloc_cnt got=%h/%h exp=%h/%h", br_cnt, miss_cnt, exp_br, exp_miss); else pass_cnt++;
    total_cnt++; if (pred_taken !== 1'b1) $display("FAIL alloc_pt got=%h exp=1", pred_taken); else pass_cnt++;
    total_cnt++; if (pred_target !== 32'h0000_3040) $display("FAIL alloc_ptgt got=%h exp=00003040", pred_target); else pass_cnt++;
  endtask

  task automatic test_train();
    logic [4:0] pb;
    logic [4:0] pa;
    pb = 5'b11100;
    pa = 5'b11110;
    f_pc = 32'h0000_3010;
    drive(32'h0000_3010, 4'd0, 1'b0, 32'h0000_3040, 1'b1, 32'h0000_3040);
    total_cnt++; if (mispredict !== 1'b1) $display("FAIL nt1_mp got=%h exp=1", mispredict); else pass_cnt++;
    total_cnt++; if (redirect_pc !== 32'h0000_3018) $display("FAIL nt1_redir got=%h exp=00003018", redirect_pc); else pass_cnt++;
    tick(); exp_br++; exp_miss++;
    total_cnt++; if (pred_taken !== 1'b0 || pred_target !== 32'h0000_3014) $display("FAIL nt1_pred got=%h/%h exp=0/00003014", pred_taken, pred_target); else pass_cnt++;
    drive(32'h0000_3010, 4'd0, 1'b0, 32'h0000_3040, 1'b0, 32'h0000_3014);
    total_cnt++; if (mispredict !== 1'b0) $display("FAIL nt2_mp got=%h exp=0", mispredict); else pass_cnt++;
    tick(); exp_br++;
    for (int k = 0; k < 5; k++) begin
      drive(32'h0000_3010, 4'd0, 1'b1, 32'h0000_3040, pb[k], pb[k] ? 32'h0000_3040 : 32'h0000_3014);
      tick(); exp_br++; if (!pb[k]) exp_miss++;
      total_cnt++; if (pred_taken !== pa[k]) $display("FAIL sat_t%0d got=%h exp=%h", k, pred_taken, pa[k]); else pass_cnt++;
    end
    drive(32'h0000_3010, 4'd0, 1'b0, 32'h0000_3040, 1'b1, 32'h0000_3040);
    tick(); exp_br++; exp_miss++;
    total_cnt++; if (pred_taken !== 1'b1) $display("FAIL sat_nt1 got=%h exp=1", pred_taken); else pass_cnt++;
    drive(32'h0000_3010, 4'd0, 1'b0, 32'h0000_3040, 1'b1, 32'h0000_3040);
    tick(); exp_br++; exp_miss++;
    total_cnt++; if (pred_taken !== 1'b0) $display("FAIL sat_nt2 got=%h exp=0", pred_taken); else pass_cnt++;
    total_cnt++; if (br_cnt !== exp_br || miss_cnt !== exp_miss) $display("FAIL train_cnt got=%h/%h exp=%h/%h", br_cnt, miss_cnt, exp_br, exp_miss); else pass_cnt++;
  endtask

  task automatic test_stall();
    f_pc = 32'h0000_3020;
    for (int k = 0; k < 3; k++) begin
      stall = 1'b1;
      drive(32'h0000_3020, 4'd1, 1'b1, 32'h0000_3100, 1'b0, 32'h0000_3024);
      total_cnt++; if (mispredict !== 1'b0) $display("FAIL stall_mp%0d got=%h exp=0", k, mispredict); else pass_cnt++;
      tick();
    end
    total_cnt++; if (br_cnt !== exp_br || miss_cnt !== exp_miss || pred_taken !== 1'b0) $display("FAIL stall_hold got=%h/%h/%h exp=%h/%h/0", br_cnt, miss_cnt, pred_taken, exp_br, exp_miss); else pass_cnt++;
    drive(32'h0000_3020, 4'd1, 1'b1, 32'h0000_3100, 1'b0, 32'h0000_3024);
    total_cnt++; if (mispredict !== 1'b1) $display("FAIL stall_rel_mp got=%h exp=1", mispredict); else pass_cnt++;
    tick(); exp_br++; exp_miss++;
    total_cnt++; if (br_cnt !== exp_br || miss_cnt !== exp_miss) $display("FAIL stall_cnt got=%h/%h exp=%h/%h", br_cnt, miss_cnt, exp_br, exp_miss); else pass_cnt++;
    total_cnt++; if (pred_taken !== 1'b1 || pred_target !== 32'h0000_3100) $display("FAIL stall_pred got=%h/%h exp=1/00003100", pred_taken, pred_target); else pass_cnt++;
  endtask

  task automatic test_nonbranch();
    f_pc = 32'h0000_3030;
    drive(32'h0000_3030, 4'd7, 1'b1, 32'h0000_3200, 1'b0, 32'h0000_3034);
    total_cnt++; if (mispredict !== 1'b0) $display("FAIL nb_mp got=%h exp=0", mispredict); else pass_cnt++;
    tick();
    total_cnt++; if (br_cnt !== exp_br || miss_cnt !== exp_miss || pred_taken !== 1'b0) $display("FAIL nb_state got=%h/%h/%h exp=%h/%h/0", br_cnt, miss_cnt, pred_taken, exp_br, exp_miss); else pass_cnt++;
  endtask

  task automatic test_alias();
    f_pc = 32'h0000_3010;
    drive(32'h0000_3010, 4'd0, 1'b1, 32'h0000_3040, 1'b0, 32'h0000_3014);
    tick(); exp_br++; exp_miss++;
    total_cnt++; if (pred_taken !== 1'b1) $display("FAIL alias_first got=%h exp=1", pred_taken); else pass_cnt++;
    drive(32'h0000_3050, 4'd2, 1'b1, 32'h0000_3300, 1'b0, 32'h0000_3054);
    tick(); exp_br++; exp_miss++;
    total_cnt++; if (pred_taken !== 1'b0 || pred_target !== 32'h0000_3014) $display("FAIL alias_evict got=%h/%h exp=0/00003014", pred_taken, pred_target); else pass_cnt++;
    f_pc = 32'h0000_3050; #1;
    total_cnt++; if (pred_taken !== 1'b1 || pred_target !== 32'h0000_3300) $display("FAIL alias_second got=%h/%h exp=1/00003300", pred_taken, pred_target); else pass_cnt++;
    drive(32'h0000_3010, 4'd0, 1'b0, 32'h0000_3040, 1'b0, 32'h0000_3014);
    total_cnt++; if (mispredict !== 1'b0) $display("FAIL alias_ntmiss_mp got=%h exp=0", mispredict); else pass_cnt++;
    tick(); exp_br++;
    total_cnt++; if (pred_taken !== 1'b1 || pred_target !== 32'h0000_3300) $display("FAIL alias_keep got=%h/%h exp=1/00003300", pred_taken, pred_target); else pass_cnt++;
  endtask

  task automatic test_target_change();
    f_pc = 32'h0000_3064;
    drive(32'h0000_3064, 4'd3, 1'b1, 32'h0000_0040, 1'b0, 32'h0000_3068);
    tick(); exp_br++; exp_miss++;
    total_cnt++; if (pred_taken !== 1'b1 || pred_target !== 32'h0000_0040) $display("FAIL tc_alloc got=%h/%h exp=1/00000040", pred_taken, pred_target); else pass_cnt++;
    drive(32'h0000_3064, 4'd3, 1'b1, 32'h0000_0080, 1'b1, 32'h0000_0040);
    total_cnt++; if (mispredict !== 1'b1 || redirect_pc !== 32'h0000_0080) $display("FAIL tc_mp got=%h/%h exp=1/00000080", mispredict, redirect_pc); else pass_cnt++;
    tick(); exp_br++; exp_miss++;
    total_cnt++; if (pred_target !== 32'h0000_0080) $display("FAIL tc_newtgt got=%h exp=00000080", pred_target); else pass_cnt++;
    drive(32'h0000_3064, 4'd3, 1'b1, 32'h0000_0080, 1'b1, 32'h0000_0080);
    total_cnt++; if (mispredict !== 1'b0) $display("FAIL tc_correct got=%h exp=0", mispredict); else pass_cnt++;
    tick(); exp_br++;
    total_cnt++; if (br_cnt !== exp_br || miss_cnt !== exp_miss) $display("FAIL tc_cnt got=%h/%h exp=%h/%h", br_cnt, miss_cnt, exp_br, exp_miss); else pass_cnt++;
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.br_cnt_q = 32'hFFFF_FFFF;
    force dut.miss_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.br_cnt_q;
    release dut.miss_cnt_q;
    drive(32'h0000_3064, 4'd0, 1'b1, 32'h0000_0080, 1'b0, 32'h0000_3068);
    tick(); exp_br = 0; exp_miss = 0;
    total_cnt++; if (br_cnt !== exp_br || miss_cnt !== exp_miss) $display("FAIL wrap got=%h/%h exp=0/0", br_cnt, miss_cnt); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    f_pc = 32'h0000_3050;
    drive(32'h0000_3070, 4'd0, 1'b1, 32'h0000_3400, 1'b0, 32'h0000_3074);
    #2; rst_n = 1'b0; #1;
    total_cnt++; if (pred_taken !== 1'b0 || pred_target !== 32'h0000_3054) $display("FAIL arst_pred got=%h/%h exp=0/00003054", pred_taken, pred_target); else pass_cnt++;
    total_cnt++; if (mispredict !== 1'b0) $display("FAIL arst_mp got=%h exp=0", mispredict); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (br_cnt !== 32'd0 || miss_cnt !== 32'd0) $display("FAIL arst_cnt got=%h/%h exp=0/0", br_cnt, miss_cnt); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1; upd_valid = 1'b0;
    f_pc = 32'h0000_3070; #1;
    total_cnt++; if (pred_taken !== 1'b0) $display("FAIL arst_lost got=%h exp=0", pred_taken); else pass_cnt++;
    f_pc = 32'h0000_3064; #1;
    total_cnt++; if (pred_taken !== 1'b0) $display("FAIL arst_clear got=%h exp=0", pred_taken); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_train();
    test_stall();
    test_nonbranch();
    test_alias();
    test_target_change();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
